// File: rtl/sobel_stream_if.sv
// Pixel stream bundle for the Sobel core: valid/ready input stream in, valid/ready result stream out.
// The core uses the slave view; the pixel source and result sink use the master view.
interface sobel_stream_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel engine: two line buffers feed a shifting window (stage 1);
// gradients, mode select and the output register form stage 2.
module sobel_stream_core #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [PIX_W+2:0] thresh,
    sobel_stream_if.slave    s
);
    localparam int GW = PIX_W + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [GW-1:0] PIX_MAX  = GW'((1 << PIX_W) - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    logic [PIX_W-1:0] win [3][3];
    logic [2:1]       vld_pipe;
    logic             s1_last;
    logic [1:0]       mode_q;
    logic [GW-1:0]    thresh_q;
    logic [PIX_W-1:0] out_data_q;
    logic             out_last_q;

    logic stall, xfer;
    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        ax, ay, mag;
    logic [PIX_W-1:0]     result;

    assign stall      = vld_pipe[2] && !s.out_ready;
    assign s.in_ready = !rst && !stall;
    assign xfer       = s.in_valid && s.in_ready;

    assign s.out_valid = vld_pipe[2];
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic signed [GW-1:0] ext2(input logic [PIX_W-1:0] p);
        return $signed({2'b00, p, 1'b0});
    endfunction

    function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
        return (v > PIX_MAX) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
    endfunction

    // Line buffers and window carry no reset: output gating on row/col hides stale contents.
    always_ff @(posedge clk) begin
        if (xfer) begin
            lb0[col] <= lb1[col];
            lb1[col] <= s.in_data;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0[col];
            win[1][2] <= lb1[col];
            win[2][2] <= s.in_data;
        end
    end

    assign gx = (ext(win[0][2]) + ext2(win[1][2]) + ext(win[2][2]))
              - (ext(win[0][0]) + ext2(win[1][0]) + ext(win[2][0]));
    assign gy = (ext(win[2][0]) + ext2(win[2][1]) + ext(win[2][2]))
              - (ext(win[0][0]) + ext2(win[0][1]) + ext(win[0][2]));
    assign ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    assign ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    assign mag = ax + ay;

    always_comb begin
        result = '0;
        case (mode_q)
            2'd0: result = sat(mag);
            2'd1: result = (mag >= thresh_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            2'd2: result = sat(ax);
            2'd3: result = sat(ay);
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            vld_pipe   <= '0;
            s1_last    <= 1'b0;
            mode_q     <= 2'd0;
            thresh_q   <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else if (!stall) begin
            vld_pipe[1] <= xfer && (row >= RW'(2)) && (col >= CW'(2));
            s1_last     <= xfer && (row == ROW_LAST) && (col == COL_LAST);
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
                out_data_q <= result;
                out_last_q <= s1_last;
            end
            if (xfer) begin
                // Configuration is frozen per frame, taken with the first pixel.
                if (col == '0 && row == '0) begin
                    mode_q   <= mode;
                    thresh_q <= thresh;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end
endmodule

// File: doc/sobel_stream_core.md
# sobel_stream_core

Streaming, parametrised Sobel engine. Consumes a raster-order pixel stream through a valid/ready handshake and builds the 3x3 window internally from two on-chip line buffers, replacing explicit windowBuffer/move_control address walking. Computes horizontal and vertical gradients, then one of four selectable outputs per interior pixel. Sits between the pixel read path and the write-back path of the edge-detection datapath.

## Interface
- PIX_W, 8: pixel width in bits, unsigned.
- IMG_W, 64: image width in pixels, at least 3.
- IMG_H, 64: image height in pixels, at least 3.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- mode  in  2  output select: 0 = saturated magnitude, 1 = binary threshold, 2 = |gx| only, 3 = |gy| only.
- thresh  in  PIX_W+3  threshold for mode 1.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  core accepts the pixel this cycle.
- in_data  in  PIX_W  input pixel.
- out_valid  out  1  output pixel valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  PIX_W  result pixel.
- out_last  out  1  marks the final output pixel of a frame.

## Operation
- An input transfer occurs when in_valid and in_ready are both high.
- Column counter runs 0..IMG_W-1 and row counter runs 0..IMG_H-1, both advancing per transfer. After (IMG_W-1, IMG_H-1) both counters wrap to 0, and the next pixel starts a new frame.
- Two line buffers, each IMG_W x PIX_W, hold the previous two rows. A 3x3 register window shifts one column per transfer.
  - Window row 0 is the oldest row; column 2 is the newest pixel.
- A window is complete when the transfer occurs at row >= 2 and col >= 2. Only complete windows produce output, so each frame yields (IMG_W-2)*(IMG_H-2) outputs centred on (row-1, col-1). Border pixels produce no output.
- Gradients use signed PIX_W+3 bits:
  - gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20)
  - gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02)
  - mag = |gx| + |gy|, unsigned PIX_W+3 bits, never overflows.
- Output by mode:
  - mode 0: min(mag, 2^PIX_W-1).
  - mode 1: all ones if mag >= thresh, else 0.
  - mode 2: saturated |gx|.
  - mode 3: saturated |gy|.
- mode and thresh are latched on the transfer at (0,0). Changes mid-frame take effect on the next frame.
- out_last is high with the output for the input at (IMG_W-1, IMG_H-1).

## Timing
- Two-stage pipeline:
  - Stage 1: window and line-buffer update on the transfer edge.
  - Stage 2: gradient, mode selection and output register.
- Latency: a window-completing transfer in cycle t gives out_valid in cycle t+2 when there is no stall.
- Stall: stall = out_valid and not out_ready.
  - in_ready = not rst and not stall (combinational).
  - During a stall, every register, counter and line buffer holds. out_data and out_last stay stable until accepted.
- Throughput: one pixel per cycle when there is no stall.
- Reset values: out_valid 0, out_data 0, out_last 0, counters 0, stage valids 0, latched mode 0, latched thresh 0. in_ready is 0 while rst is high.
- Line buffer contents are not cleared. They are don't-care because the row < 2 gating suppresses output.
- Reset mid-frame aborts the frame: in-flight outputs are discarded and the next transfer is treated as (0,0).
- A transfer and an output acceptance in the same cycle are both honoured with no bubble.

## Test plan
All scenarios use IMG_W=8, IMG_H=6, PIX_W=8.
- Flat frame, every pixel 100, mode 0 -> exactly 24 outputs, all 0. out_last only on the 24th. First out_valid two cycles after the transfer at (2,2).
- Vertical step, columns 0-3 = 0 and columns 4-7 = 255, mode 0 -> output centre columns 3 and 4 = 255 (gx = 1020, saturated); centre columns 1, 2, 5, 6 = 0.
- Horizontal ramp, pixel = 10*col, giving gx = 80 and gy = 0:
  - mode 1 with thresh 80 -> all 255.
  - mode 1 with thresh 81 -> all 0.
  - mode 2 -> all 80.
  - mode 3 -> all 0.
- Random frame, out_ready low for 5 cycles mid-frame -> in_ready low throughout, out_data stable, and the output sequence is bit-identical to an unstalled run.
- Assert rst for 1 cycle after 20 transfers, then stream a full step frame -> exactly 24 correct outputs, with no residue from the aborted frame.
- Two back-to-back frames, with mode changed from 0 to 2 at the 10th transfer of frame 1 -> frame 1 is entirely mode 0, frame 2 is entirely mode 2, and no gap cycle is needed between frames.
